cv32e40p_xmem_responder: RTL and testbench
==========================================

Name: cv32e40p_xmem_responder

Overview:
Core-side responder for the Xmem channel. It accepts memory requests that the accelerator subsystem issues on xmem_q, performs them on the core's OBI data port, and returns ordered results on xmem_p. It sits in the core between the X-interface and the data-memory bus, sharing that bus with the core LSU.

Parameters:
RSP_DEPTH, 2, response buffer entries; also the maximum number of bus transactions in flight (≥1).

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
core_lsu_busy_i  in  1  core LSU owns data bus; no new bus request may start
xmem_q_valid_i  in  1  request valid
xmem_q_ready_o  out  1  request ready
xmem_q_laddr_i  in  32  byte address
xmem_q_wdata_i  in  32  store data, LSB-aligned
xmem_q_width_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
xmem_q_req_type_i  in  cv32e40p_x_if_pkg::mem_req_type_e  READ or WRITE
xmem_q_mode_i  in  1  accepted, ignored
xmem_q_spec_i  in  1  accepted, ignored
xmem_q_endoftransaction_i  in  1  last request of an accelerator transaction
xmem_p_valid_o  out  1  response valid
xmem_p_ready_i  in  1  response ready
xmem_p_rdata_o  out  32  load data, extended
xmem_p_range_o  out  5  valid bits minus 1: 7, 15 or 31
xmem_p_status_o  out  1  0 ok, 1 error
xmem_busy_o  out  1  accelerator transaction open
data_req_o  out  1  OBI request
data_gnt_i  in  1  OBI grant
data_addr_o  out  32  word-aligned address
data_we_o  out  1  write enable
data_be_o  out  4  byte enables
data_wdata_o  out  32  lane-shifted store data
data_rvalid_i  in  1  OBI response valid
data_rdata_i  in  32  OBI read data
data_err_i  in  1  OBI bus error

Behaviour:
- Reset:
  - All registered outputs are 0: data_req_o, xmem_p_valid_o, xmem_busy_o.
  - Buffer is empty; in-flight count is 0.
- Request register (1 entry), xmem_q_ready_o = register empty. Accept on valid&ready.
  - Store laddr[1:0], width, req_type, wdata, eot.
- Misaligned requests: H with laddr[0]=1, or W with laddr[1:0]≠0.
  - No bus access.
  - Once in-flight = 0 and the buffer is not full, push {rdata=0, range per width, status=1} and free the register.
- Aligned requests, FSM IDLE→REQ→IDLE:
  - IDLE→REQ when the register is valid, core_lsu_busy_i=0, and in-flight + buffered < RSP_DEPTH. data_req_o rises the cycle after that.
  - In REQ, data_req_o and all address/data outputs stay stable until data_gnt_i. On grant the register frees, in-flight increments, and the state returns to IDLE.
  - No new request is issued in the grant cycle. Earliest accept-to-req latency is 1 cycle.
  - core_lsu_busy_i rising while in REQ does not withdraw the request.
- Bus mapping:
  - data_addr_o = {laddr[31:2],2'b00}.
  - data_be_o: B=0001<<laddr[1:0]; H=0011<<laddr[1:0]; W=1111.
  - data_wdata_o = wdata<<(8*laddr[1:0]).
  - data_we_o = (req_type==WRITE).
- OBI response (data_rvalid_i):
  - In-flight decrements.
  - Push into the buffer: rdata>>8*offset, then sign-extend (width[2]=0) or zero-extend (width[2]=1) to the width. Writes return rdata=0.
  - status=data_err_i; range 7/15/31 by width[1:0].
  - Per-transaction offset/width/eot travels in a small in-order side FIFO, depth RSP_DEPTH.
  - The credit check guarantees space, so data_rvalid_i is never dropped.
- Response buffer:
  - FIFO of depth RSP_DEPTH.
  - xmem_p_valid_o = not empty; pop on valid&ready.
  - Outputs are stable while valid&!ready.
  - Simultaneous push and pop when full is not possible (credit rule). Simultaneous push and pop when empty passes through in the next cycle; there is no same-cycle bypass.
- Ordering: responses are returned strictly in request acceptance order, including error responses.
- xmem_busy_o:
  - Set on the cycle after any accept.
  - Cleared on the cycle after pop of a response whose eot=1, unless another accept occurs in that same cycle.
- Reset mid-operation: asynchronously clears all state; in-flight OBI responses after reset are ignored.

Test Plan:
- LW at 0x1000 on an idle bus, gnt same cycle, rvalid 1 cycle later with 0xDEADBEEF → data_addr_o=0x1000, be=1111, xmem_p rdata=0xDEADBEEF, range=31, status=0.
- LB at 0x1003, rdata=0x80FFFFFF → be=1000, rdata=0xFFFFFF80; LBU at the same address → rdata=0x00000080, range=7.
- SH wdata=0x1234 at 0x2002 → be=1100, data_wdata_o=0x12340000, we=1; response rdata=0, range=15, status=0.
- LW at 0x1001 → no data_req_o; response status=1, rdata=0, issued only after an earlier in-flight LW response.
- RSP_DEPTH=2, xmem_p_ready_i=0, three LW back-to-back → exactly two granted; the third data_req_o appears only after the first pop; order is preserved.
- core_lsu_busy_i=1 for 5 cycles with a pending request → no data_req_o; eot request → xmem_busy_o drops the cycle after its response pops; OBI data_err_i=1 → status=1.

Source files
------------

// File: rtl/cv32e40p_xmem_responder.sv
// Xmem responder: takes accelerator memory requests from xmem_q, runs them on
// the core OBI data port (shared with the LSU) and returns in-order results on
// xmem_p. Misaligned H/W requests never reach the bus and return status=1.
//
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   core_lsu_busy_i                  LSU owns the data bus; hold off new requests
//   xmem_q_*                         request channel (valid/ready)
//   xmem_p_*                         response channel (valid/ready)
//   xmem_busy_o                      accelerator transaction open
//   data_*                           OBI data master port

package cv32e40p_x_if_pkg;
  typedef enum logic [1:0] {
    READ  = 2'b00,
    WRITE = 2'b01
  } mem_req_type_e;
endpackage

package cv32e40p_xmem_responder_pkg;
  // Entry of the response buffer.
  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rng;
    logic        status;
    logic        eot;
  } xmem_rsp_t;

  // Per-transaction info that follows a granted request to its OBI response.
  typedef struct packed {
    logic [1:0] offset;
    logic [2:0] width;
    logic       we;
    logic       eot;
  } xmem_side_t;
endpackage

module cv32e40p_xmem_responder
  import cv32e40p_x_if_pkg::*;
  import cv32e40p_xmem_responder_pkg::*;
#(
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             core_lsu_busy_i,
  input  logic                             xmem_q_valid_i,
  output logic                             xmem_q_ready_o,
  input  logic [31:0]                      xmem_q_laddr_i,
  input  logic [31:0]                      xmem_q_wdata_i,
  input  logic [2:0]                       xmem_q_width_i,
  input  cv32e40p_x_if_pkg::mem_req_type_e xmem_q_req_type_i,
  input  logic                             xmem_q_mode_i,
  input  logic                             xmem_q_spec_i,
  input  logic                             xmem_q_endoftransaction_i,
  output logic                             xmem_p_valid_o,
  input  logic                             xmem_p_ready_i,
  output logic [31:0]                      xmem_p_rdata_o,
  output logic [4:0]                       xmem_p_range_o,
  output logic                             xmem_p_status_o,
  output logic                             xmem_busy_o,
  output logic                             data_req_o,
  input  logic                             data_gnt_i,
  output logic [31:0]                      data_addr_o,
  output logic                             data_we_o,
  output logic [3:0]                       data_be_o,
  output logic [31:0]                      data_wdata_o,
  input  logic                             data_rvalid_i,
  input  logic [31:0]                      data_rdata_i,
  input  logic                             data_err_i
);

  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_e;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [4:0] range_of(input logic [1:0] w);
    case (w)
      2'b00:   return 5'd7;
      2'b01:   return 5'd15;
      default: return 5'd31;
    endcase
  endfunction

  // mode/spec are accepted but carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{xmem_q_mode_i, xmem_q_spec_i};

  state_e        state_q, state_d;
  logic          rq_valid_q;
  logic [31:0]   rq_addr_q;
  logic [31:0]   rq_wdata_q;
  logic [2:0]    rq_width_q;
  mem_req_type_e rq_type_q;
  logic          rq_eot_q;
  logic          rq_mis;

  logic          accept, issue, grant_take, err_push, rsp_push, rsp_pop;
  logic          credit_ok;
  logic [CW-1:0] inflight_q;

  xmem_side_t    side_mem [RSP_DEPTH];
  logic [PW-1:0] side_wr_q, side_rd_q;
  xmem_side_t    side_head;

  xmem_rsp_t     rsp_mem [RSP_DEPTH];
  logic [PW-1:0] rsp_wr_q, rsp_rd_q;
  logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;
  logic          rsp_full;
  logic          p_valid_q;
  xmem_rsp_t     rsp_head, push_entry;

  logic [31:0]   ld_shift, ld_ext;
  logic [3:0]    be_c;

  assign accept         = xmem_q_valid_i && xmem_q_ready_o;
  assign xmem_q_ready_o = !rq_valid_q;
  assign rsp_full       = (rsp_cnt_q == CW'(RSP_DEPTH));
  assign credit_ok      = (({1'b0, inflight_q} + {1'b0, rsp_cnt_q}) < (CW + 1)'(RSP_DEPTH));
  // responses arriving with nothing outstanding (e.g. after reset) are dropped
  assign rsp_push       = data_rvalid_i && (inflight_q != '0);
  assign rsp_pop        = p_valid_q && xmem_p_ready_i;

  // Misalignment of the held request
  always_comb begin
    rq_mis = 1'b0;
    case (rq_width_q[1:0])
      2'b01:   rq_mis = rq_addr_q[0];
      2'b10:   rq_mis = (rq_addr_q[1:0] != 2'b00);
      default: rq_mis = 1'b0;
    endcase
  end

  // Request register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rq_valid_q <= 1'b0;
      rq_addr_q  <= '0;
      rq_wdata_q <= '0;
      rq_width_q <= '0;
      rq_type_q  <= READ;
      rq_eot_q   <= 1'b0;
    end else if (accept) begin
      rq_valid_q <= 1'b1;
      rq_addr_q  <= xmem_q_laddr_i;
      rq_wdata_q <= xmem_q_wdata_i;
      rq_width_q <= xmem_q_width_i;
      rq_type_q  <= xmem_q_req_type_i;
      rq_eot_q   <= xmem_q_endoftransaction_i;
    end else if (grant_take || err_push) begin
      rq_valid_q <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (rq_valid_q && !rq_mis && !core_lsu_busy_i && credit_ok) state_d = S_REQ;
      S_REQ:  if (data_gnt_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM strobes
  always_comb begin
    issue      = 1'b0;
    grant_take = 1'b0;
    err_push   = 1'b0;
    case (state_q)
      S_IDLE: begin
        issue    = (state_d == S_REQ);
        err_push = rq_valid_q && rq_mis && (inflight_q == '0) && !rsp_full;
      end
      S_REQ:   grant_take = data_gnt_i;
      default: ;
    endcase
  end

  // Byte-lane enables of the held request
  always_comb begin
    case (rq_width_q[1:0])
      2'b00:   be_c = 4'(4'b0001 << rq_addr_q[1:0]);
      2'b01:   be_c = 4'(4'b0011 << rq_addr_q[1:0]);
      default: be_c = 4'b1111;
    endcase
  end

  // OBI request outputs, captured at issue and held until grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_req_o   <= 1'b0;
      data_addr_o  <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_wdata_o <= '0;
    end else begin
      data_req_o <= (state_d == S_REQ);
      if (issue) begin
        data_addr_o  <= {rq_addr_q[31:2], 2'b00};
        data_we_o    <= (rq_type_q == WRITE);
        data_be_o    <= be_c;
        data_wdata_o <= rq_wdata_q << {rq_addr_q[1:0], 3'b000};
      end
    end
  end

  // Outstanding bus transactions
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
    end else begin
      case ({grant_take, rsp_push})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: ;
      endcase
    end
  end

  // Side FIFO pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      side_wr_q <= '0;
      side_rd_q <= '0;
    end else begin
      if (grant_take) side_wr_q <= ptr_inc(side_wr_q);
      if (rsp_push)   side_rd_q <= ptr_inc(side_rd_q);
    end
  end

  // Side FIFO storage
  always_ff @(posedge clk_i) begin
    if (grant_take) begin
      side_mem[side_wr_q] <= '{offset: rq_addr_q[1:0], width: rq_width_q,
                               we: (rq_type_q == WRITE), eot: rq_eot_q};
    end
  end

  // Load alignment and extension of the OBI response
  always_comb begin
    side_head = side_mem[side_rd_q];
    ld_shift  = data_rdata_i >> {side_head.offset, 3'b000};
    case (side_head.width[1:0])
      2'b00:   ld_ext = side_head.width[2] ? {24'h0, ld_shift[7:0]}
                                           : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_ext = side_head.width[2] ? {16'h0, ld_shift[15:0]}
                                           : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
    if (side_head.we) ld_ext = '0;
  end

  // Response buffer write selection (bus response and error push never coincide)
  always_comb begin
    if (rsp_push) begin
      push_entry = '{rdata: ld_ext, rng: range_of(side_head.width[1:0]),
                     status: data_err_i, eot: side_head.eot};
    end else begin
      push_entry = '{rdata: 32'h0, rng: range_of(rq_width_q[1:0]),
                     status: 1'b1, eot: rq_eot_q};
    end
  end

  always_comb begin
    rsp_cnt_d = rsp_cnt_q;
    case ({rsp_push || err_push, rsp_pop})
      2'b10:   rsp_cnt_d = rsp_cnt_q + CW'(1);
      2'b01:   rsp_cnt_d = rsp_cnt_q - CW'(1);
      default: ;
    endcase
  end

  // Response buffer pointers and valid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_wr_q  <= '0;
      rsp_rd_q  <= '0;
      rsp_cnt_q <= '0;
      p_valid_q <= 1'b0;
    end else begin
      if (rsp_push || err_push) rsp_wr_q <= ptr_inc(rsp_wr_q);
      if (rsp_pop)              rsp_rd_q <= ptr_inc(rsp_rd_q);
      rsp_cnt_q <= rsp_cnt_d;
      p_valid_q <= (rsp_cnt_d != '0);
    end
  end

  // Response buffer storage
  always_ff @(posedge clk_i) begin
    if (rsp_push || err_push) rsp_mem[rsp_wr_q] <= push_entry;
  end

  assign rsp_head        = rsp_mem[rsp_rd_q];
  assign xmem_p_valid_o  = p_valid_q;
  assign xmem_p_rdata_o  = rsp_head.rdata;
  assign xmem_p_range_o  = rsp_head.rng;
  assign xmem_p_status_o = rsp_head.status;

  // Transaction-open flag; a new accept wins over an eot pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     xmem_busy_o <= 1'b0;
    else if (accept)                 xmem_busy_o <= 1'b1;
    else if (rsp_pop && rsp_head.eot) xmem_busy_o <= 1'b0;
  end

endmodule

// File: tb/tb_cv32e40p_xmem_responder.sv
// Bench for cv32e40p_xmem_responder: request table plus directed sequences,
// an OBI slave model and a response scoreboard, all stepped on the falling edge.
module tb_cv32e40p_xmem_responder;
  import cv32e40p_x_if_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_lsu_busy_i;
  logic          xmem_q_valid_i, xmem_q_ready_o;
  logic [31:0]   xmem_q_laddr_i, xmem_q_wdata_i;
  logic [2:0]    xmem_q_width_i;
  mem_req_type_e xmem_q_req_type_i;
  logic          xmem_q_mode_i, xmem_q_spec_i, xmem_q_endoftransaction_i;
  logic          xmem_p_valid_o, xmem_p_ready_i;
  logic [31:0]   xmem_p_rdata_o;
  logic [4:0]    xmem_p_range_o;
  logic          xmem_p_status_o, xmem_busy_o;
  logic          data_req_o, data_gnt_i, data_we_o;
  logic [31:0]   data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]    data_be_o;
  logic          data_rvalid_i, data_err_i;

  always #5 clk = ~clk;

  cv32e40p_xmem_responder #(.RSP_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .core_lsu_busy_i(core_lsu_busy_i),
    .xmem_q_valid_i(xmem_q_valid_i), .xmem_q_ready_o(xmem_q_ready_o),
    .xmem_q_laddr_i(xmem_q_laddr_i), .xmem_q_wdata_i(xmem_q_wdata_i),
    .xmem_q_width_i(xmem_q_width_i), .xmem_q_req_type_i(xmem_q_req_type_i),
    .xmem_q_mode_i(xmem_q_mode_i), .xmem_q_spec_i(xmem_q_spec_i),
    .xmem_q_endoftransaction_i(xmem_q_endoftransaction_i),
    .xmem_p_valid_o(xmem_p_valid_o), .xmem_p_ready_i(xmem_p_ready_i),
    .xmem_p_rdata_o(xmem_p_rdata_o), .xmem_p_range_o(xmem_p_range_o),
    .xmem_p_status_o(xmem_p_status_o), .xmem_busy_o(xmem_busy_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
  );

  typedef struct {
    logic [31:0] addr;  logic [31:0] wdata; logic [2:0] width; logic we; logic eot;
    logic [31:0] bus_rdata; logic bus_err; logic bus;
    logic [3:0]  be;    logic [31:0] bwdata;
    logic [31:0] rdata; logic [4:0] rng; logic status;
  } vec_t;
  typedef struct {
    logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we;
    logic [31:0] rdata; logic err;
  } bus_t;
  typedef struct { logic [31:0] rdata; logic [4:0] rng; logic status; } rsp_t;

  vec_t req_q[$];
  bus_t bus_q[$];
  rsp_t exp_q[$];
  vec_t tbl[14];

  int   n_vec = 0, n_err = 0, grants = 0;
  bit   gnt_en = 1, gnt_rand = 0, p_rand = 0, p_ready = 1, lsu_busy = 0;
  bit   inject_rv = 0, rsp_pend = 0;
  bus_t rsp_ent;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] width, input logic we, input logic eot,
                               input logic [31:0] brd, input logic berr, input logic bus,
                               input logic [3:0] be, input logic [31:0] bwd,
                               input logic [31:0] rd, input logic [4:0] rng, input logic st);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.width = width; v.we = we; v.eot = eot;
    v.bus_rdata = brd; v.bus_err = berr; v.bus = bus; v.be = be; v.bwdata = bwd;
    v.rdata = rd; v.rng = rng; v.status = st;
    return v;
  endfunction

  function automatic vec_t lw(input logic [31:0] a, input logic [31:0] d, input logic eot);
    return mkv(a, 32'h0, 3'b010, 1'b0, eot, d, 1'b0, 1'b1, 4'hF, 32'h0, d, 5'd31, 1'b0);
  endfunction

  // One clock: OBI slave, request source, response scoreboard
  task automatic step();
    vec_t v; bus_t b; rsp_t r;
    @(negedge clk);
    core_lsu_busy_i = lsu_busy;
    xmem_p_ready_i  = p_rand ? 1'($urandom_range(0, 1)) : p_ready;

    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'h0;
    if (rsp_pend) begin
      data_rvalid_i = 1'b1; data_rdata_i = rsp_ent.rdata; data_err_i = rsp_ent.err;
      rsp_pend = 0;
    end
    if (inject_rv) begin
      data_rvalid_i = 1'b1; data_rdata_i = 32'hBAD0BAD0; inject_rv = 0;
    end
    if (data_req_o && gnt_en && (!gnt_rand || $urandom_range(0, 1) == 1)) begin
      data_gnt_i = 1'b1;
      grants++;
      check("bus_pending", 32'(bus_q.size()), 32'd1);
      if (bus_q.size() > 0) begin
        b = bus_q.pop_front();
        check("bus_addr", data_addr_o, b.addr);
        check("bus_be", 32'(data_be_o), 32'(b.be));
        check("bus_wdata", data_wdata_o, b.wdata);
        check("bus_we", 32'(data_we_o), 32'(b.we));
        rsp_ent = b; rsp_pend = 1;
      end
    end

    if (req_q.size() > 0) begin
      v = req_q[0];
      xmem_q_valid_i = 1'b1; xmem_q_laddr_i = v.addr; xmem_q_wdata_i = v.wdata;
      xmem_q_width_i = v.width; xmem_q_req_type_i = v.we ? WRITE : READ;
      xmem_q_endoftransaction_i = v.eot;
      xmem_q_mode_i = 1'($urandom_range(0, 1)); xmem_q_spec_i = 1'($urandom_range(0, 1));
      if (xmem_q_ready_o) begin
        r.rdata = v.rdata; r.rng = v.rng; r.status = v.status;
        exp_q.push_back(r);
        if (v.bus) begin
          b.addr = {v.addr[31:2], 2'b00}; b.be = v.be; b.wdata = v.bwdata; b.we = v.we;
          b.rdata = v.bus_rdata; b.err = v.bus_err;
          bus_q.push_back(b);
        end
        void'(req_q.pop_front());
      end
    end else begin
      xmem_q_valid_i = 1'b0;
    end

    if (xmem_p_valid_o && xmem_p_ready_i) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h, required no response", xmem_p_rdata_o);
      end else begin
        r = exp_q.pop_front();
        check("rsp_rdata", xmem_p_rdata_o, r.rdata);
        check("rsp_range", 32'(xmem_p_range_o), 32'(r.rng));
        check("rsp_status", 32'(xmem_p_status_o), 32'(r.status));
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && (req_q.size() > 0 || exp_q.size() > 0); k++) step();
    check("drain_left", 32'(req_q.size() + exp_q.size()), 32'd0);
    check("bus_left", 32'(bus_q.size()), 32'd0);
  endtask

  initial begin
    int g0;
    vec_t v;
    // addr, wdata, width, we, eot, bus_rdata, bus_err, bus, be, bus_wdata, rdata, range, status
    tbl[0]  = mkv(32'h1000, 32'h0,      3'b010, 0, 0, 32'hDEADBEEF, 0, 1, 4'hF, 32'h0,      32'hDEADBEEF, 31, 0);
    tbl[1]  = mkv(32'h1003, 32'h0,      3'b000, 0, 0, 32'h80FFFFFF, 0, 1, 4'h8, 32'h0,      32'hFFFFFF80, 7,  0);
    tbl[2]  = mkv(32'h1003, 32'h0,      3'b100, 0, 0, 32'h80FFFFFF, 0, 1, 4'h8, 32'h0,      32'h00000080, 7,  0);
    tbl[3]  = mkv(32'h2002, 32'h1234,   3'b001, 1, 0, 32'hFFFFFFFF, 0, 1, 4'hC, 32'h12340000, 32'h0,      15, 0);
    tbl[4]  = mkv(32'h1002, 32'h0,      3'b001, 0, 0, 32'h80010000, 0, 1, 4'hC, 32'h0,      32'hFFFF8001, 15, 0);
    tbl[5]  = mkv(32'h1000, 32'h0,      3'b101, 0, 0, 32'h1234F00D, 0, 1, 4'h3, 32'h0,      32'h0000F00D, 15, 0);
    tbl[6]  = mkv(32'h3001, 32'hA5,     3'b000, 1, 0, 32'h0,        0, 1, 4'h2, 32'h0000A500, 32'h0,      7,  0);
    tbl[7]  = mkv(32'h3004, 32'hCAFEF00D, 3'b010, 1, 0, 32'h0,      0, 1, 4'hF, 32'hCAFEF00D, 32'h0,      31, 0);
    tbl[8]  = mkv(32'h1001, 32'h0,      3'b010, 0, 0, 32'h0,        0, 0, 4'h0, 32'h0,      32'h0,        31, 1);
    tbl[9]  = mkv(32'h1003, 32'h0,      3'b001, 0, 0, 32'h0,        0, 0, 4'h0, 32'h0,      32'h0,        15, 1);
    tbl[10] = mkv(32'h4000, 32'h0,      3'b010, 0, 0, 32'h12345678, 1, 1, 4'hF, 32'h0,      32'h12345678, 31, 1);
    tbl[11] = mkv(32'h1001, 32'h0,      3'b000, 0, 1, 32'h00007F00, 0, 1, 4'h2, 32'h0,      32'h0000007F, 7,  0);
    tbl[12] = mkv(32'h2002, 32'h0,      3'b101, 0, 0, 32'hBEEF0000, 0, 1, 4'hC, 32'h0,      32'h0000BEEF, 15, 0);
    tbl[13] = mkv(32'h2002, 32'h55,     3'b010, 1, 1, 32'h0,        0, 0, 4'h0, 32'h0,      32'h0,        31, 1);

    rst_n = 1'b0; core_lsu_busy_i = 1'b0; xmem_q_valid_i = 1'b0; xmem_q_laddr_i = '0;
    xmem_q_wdata_i = '0; xmem_q_width_i = '0; xmem_q_req_type_i = READ; xmem_q_mode_i = 0;
    xmem_q_spec_i = 0; xmem_q_endoftransaction_i = 0; xmem_p_ready_i = 1'b1;
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = '0; data_err_i = 0;

    repeat (3) @(negedge clk);
    check("rst_req", 32'(data_req_o), 0);
    check("rst_pvalid", 32'(xmem_p_valid_o), 0);
    check("rst_busy", 32'(xmem_busy_o), 0);
    check("rst_qready", 32'(xmem_q_ready_o), 1);
    rst_n = 1'b1;

    // Each table vector on its own
    foreach (tbl[i]) begin
      req_q.push_back(tbl[i]);
      drain();
    end

    // Whole table back-to-back under random grant and response backpressure
    gnt_rand = 1; p_rand = 1;
    repeat (3) foreach (tbl[i]) req_q.push_back(tbl[i]);
    drain();
    gnt_rand = 0; p_rand = 0; p_ready = 1;

    // Misaligned request queued behind an in-flight load keeps its place
    gnt_en = 0;
    req_q.push_back(lw(32'h6000, 32'h600D600D, 0));
    req_q.push_back(tbl[8]);
    repeat (6) step();
    check("mis_waits", 32'(xmem_p_valid_o), 0);
    gnt_en = 1;
    drain();

    // LSU holds the bus: no request; eot response with bus error closes the transaction
    lsu_busy = 1; p_ready = 0;
    v = lw(32'h5000, 32'h0BADF00D, 1); v.bus_err = 1; v.status = 1;
    req_q.push_back(v);
    step(); step();
    check("busy_set", 32'(xmem_busy_o), 1);
    repeat (5) begin step(); check("lsu_hold_req", 32'(data_req_o), 0); end
    lsu_busy = 0;
    for (int k = 0; k < 20 && !xmem_p_valid_o; k++) step();
    check("eot_rsp_valid", 32'(xmem_p_valid_o), 1);
    check("busy_before_pop", 32'(xmem_busy_o), 1);
    p_ready = 1; step(); step();
    check("busy_clear", 32'(xmem_busy_o), 0);
    drain();

    // LSU busy rising mid-request does not withdraw it
    gnt_en = 0;
    req_q.push_back(lw(32'h5004, 32'h01020304, 0));
    for (int k = 0; k < 20 && !data_req_o; k++) step();
    lsu_busy = 1;
    repeat (3) begin step(); check("req_kept", 32'(data_req_o), 1); end
    gnt_en = 1; drain(); lsu_busy = 0;

    // Credit limit: two granted, third waits for a pop
    p_ready = 0; g0 = grants;
    req_q.push_back(lw(32'h7000, 32'h11111111, 0));
    req_q.push_back(lw(32'h7004, 32'h22222222, 0));
    req_q.push_back(lw(32'h7008, 32'h33333333, 1));
    repeat (12) step();
    check("two_granted", 32'(grants - g0), 2);
    check("third_held", 32'(data_req_o), 0);
    check("head_valid", 32'(xmem_p_valid_o), 1);
    step();
    check("head_stable", xmem_p_rdata_o, 32'h11111111);
    p_ready = 1; drain();
    check("three_granted", 32'(grants - g0), 3);

    // Accept-to-request latency, then reset while a request is pending
    gnt_en = 0;
    req_q.push_back(lw(32'h8000, 32'h88888888, 1));
    step(); step();
    check("req_lat0", 32'(data_req_o), 0);
    step();
    check("req_lat1", 32'(data_req_o), 1);
    rst_n = 1'b0; #1;
    check("midrst_req", 32'(data_req_o), 0);
    check("midrst_busy", 32'(xmem_busy_o), 0);
    check("midrst_qready", 32'(xmem_q_ready_o), 1);
    req_q.delete(); bus_q.delete(); exp_q.delete(); rsp_pend = 0;
    @(negedge clk); rst_n = 1'b1; gnt_en = 1; inject_rv = 1;
    repeat (3) step();
    check("stray_rvalid", 32'(xmem_p_valid_o), 0);
    req_q.push_back(lw(32'h9000, 32'hA5A5A5A5, 1));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
